// File: rtl/debounce_filter.sv
// Input conditioner: synchronises a raw asynchronous level and only passes
// changes that hold steady for STABLE_CYCLES samples; rejected changes are counted.
module debounce_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in,
  input  logic                clr_glitch,
  output logic                out,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = ($clog2(STABLE_CYCLES) < 1) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } state_t;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_filter: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("debounce_filter: STABLE_CYCLES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   glitch_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A candidate change that reverts before qualifying is a glitch.
  assign glitch_evt = ((state == ARM_HI) && !s) || ((state == ARM_LO) && s);

  // out/settling are registered alongside the state so they follow it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STABLE_LO;
      cnt      <= '0;
      out      <= 1'b0;
      settling <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (s) begin
            state    <= ARM_HI;
            cnt      <= CNT_W'(1);
            settling <= 1'b1;
          end
        end
        ARM_HI: begin
          if (!s) begin
            state    <= STABLE_LO;
            settling <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_HI;
            out      <= 1'b1;
            settling <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state    <= ARM_LO;
            cnt      <= CNT_W'(1);
            settling <= 1'b1;
          end
        end
        ARM_LO: begin
          if (s) begin
            state    <= STABLE_HI;
            settling <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_LO;
            out      <= 1'b0;
            settling <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= STABLE_LO;
          cnt      <= '0;
          out      <= 1'b0;
          settling <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident glitch; the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          glitch_cnt <= '0;
    else if (clr_glitch)                 glitch_cnt <= '0;
    else if (glitch_evt && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
  end

endmodule

// File: doc/debounce_filter.md
Name: debounce_filter

Overview:
- Upstream conditioning stage for the rising-edge detector.
- Takes a raw asynchronous level (switch or external pin), synchronises it into the clk domain, and rejects glitches.
- Drives a clean, registered level whose only transitions are held-stable changes, so the edge detector sees exactly one rising edge per real input change.
- Also provides a settling flag and a saturating glitch counter for debug visibility.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser; elaboration error if less than 2.
- STABLE_CYCLES, 16, consecutive synchronised samples of the new level required before out changes; elaboration error if less than 2.
- GLITCH_W, 8, width of the glitch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  1  raw asynchronous level.
- clr_glitch  input  1  synchronous clear of glitch_cnt.
- out  output  1  debounced level, registered.
- settling  output  1  high while a candidate change is being qualified.
- glitch_cnt  output  GLITCH_W  count of rejected candidate changes, saturating.

Behaviour:
- Reset (async, rst_n=0): all synchroniser flops 0, state STABLE_LO, qualify counter 0, out=0, settling=0, glitch_cnt=0. Effect is immediate, independent of clk. Release is taken at the next clk edge with rst_n=1.
- Synchroniser: in passes through SYNC_STAGES flops. s is the last stage. s reflects in SYNC_STAGES edges after in is sampled.
- FSM has four states, all registered (Moore):
  - STABLE_LO: s=1 -> ARM_HI, cnt=1; else stay.
  - ARM_HI: s=0 -> STABLE_LO and glitch event; else if cnt==STABLE_CYCLES-1 -> STABLE_HI; else cnt+1.
  - STABLE_HI: s=0 -> ARM_LO, cnt=1; else stay.
  - ARM_LO: s=1 -> STABLE_HI and glitch event; else if cnt==STABLE_CYCLES-1 -> STABLE_LO; else cnt+1.
- Outputs:
  - out=1 in STABLE_HI and ARM_LO; 0 in STABLE_LO and ARM_HI.
  - settling=1 in ARM_HI and ARM_LO.
  - Both outputs are decoded from the state register only, never from in or s.
- Latency:
  - If s is first 1 in cycle t and remains 1 through t+STABLE_CYCLES-1, out is 1 from cycle t+STABLE_CYCLES.
  - End to end, from the first clk edge sampling raw in=1 to out=1: SYNC_STAGES+STABLE_CYCLES cycles.
  - Falling direction is symmetric.
- Boundary conditions:
  - Exactly STABLE_CYCLES-1 stable samples followed by the opposite level: rejected, glitch event, out unchanged.
  - Exactly STABLE_CYCLES stable samples: accepted.
- Qualify counter: width clog2(STABLE_CYCLES), minimum 1. It restarts at 1 on every ARM entry and is never carried across arms.
- glitch_cnt:
  - Increments by 1 per glitch event and saturates at all ones (no wrap).
  - clr_glitch=1 sets it to 0 next edge. Clear wins over a simultaneous glitch event.
- Reset mid-operation (any state, including ARM_*): out drops to 0 asynchronously. The partial qualification is discarded and does not count as a glitch.
- No X on outputs after reset. All states reachable; an unreachable encoding recovers to STABLE_LO.

Test Plan:
- Hold rst_n=0 with in=1 -> out=0, settling=0, glitch_cnt=0 throughout. Release and keep in=1 -> out=1 exactly 18 cycles (2+16) after the first edge with rst_n=1, and settling=1 for the 16 cycles before.
- From STABLE_LO, in=1 for 5 cycles then 0 -> out stays 0, settling pulses 5 cycles, glitch_cnt=1.
- Threshold: pulse of 15 cycles -> out unchanged, glitch_cnt increments. Pulse of 16 cycles -> out rises 18 cycles after the pulse start and stays 1.
- From STABLE_HI, in=0 held -> out falls 18 cycles later. A 3-cycle low glitch -> out stays 1, glitch_cnt+1.
- GLITCH_W=8, 300 rejected pulses -> glitch_cnt=255, no wrap. Then clr_glitch asserted in the same cycle as a glitch event -> glitch_cnt=0.
- Assert rst_n=0 asynchronously mid ARM_LO (out=1) -> out=0 before the next clk edge. After release -> STABLE_LO, glitch_cnt unchanged by the aborted qualification.
